mem_write_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 16 +
 rtl/btn_sync.sv | 22 ++
 rtl/mem_write_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_write_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory write controller.
// Holds the FSM state encoding and the default/simulation sizing values.
package mem_pkg;

    localparam int unsigned MEM_DATA_W   = 8;
    localparam int unsigned MEM_ADDR_W   = 2;
    localparam int unsigned DEBOUNCE_SIM = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PULSE    = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

endpackage : mem_pkg

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops clear to 0 on reset.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule : btn_sync

// File: rtl/mem_write_ctrl.sv
// Debounced store-button controller: produces one registered store strobe per
// press with data/address frozen around it; optional auto-incrementing address.
module mem_write_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W          = MEM_DATA_W,
    parameter int unsigned ADDR_W          = MEM_ADDR_W,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_store,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic              auto_inc,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              store,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              inc_q, inc_d;
    logic              store_q, store_d;
    logic              busy_q, busy_d;
    logic              btn_s;
    logic [ADDR_W-1:0] addr_src;

    btn_sync u_btn_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (btn_store),
        .sync_o  (btn_s)
    );

    assign addr_src = auto_inc ? ptr_q : sw_addr;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            inc_q   <= 1'b0;
            store_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            inc_q   <= inc_d;
            store_q <= store_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        inc_d   = inc_q;

        case (state_q)
            ST_IDLE: begin
                data_d = sw_data;
                addr_d = addr_src;
                if (btn_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                data_d = sw_data;
                addr_d = addr_src;
                // Remember the address mode of the captured write for the pointer bump
                inc_d  = auto_inc;
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (inc_q) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
            ST_RELEASE: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        store_d = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign data_out = data_q;
    assign addr_out = addr_q;
    assign store    = store_q;
    assign busy     = busy_q;
    assign wr_ptr   = ptr_q;

endmodule : mem_write_ctrl

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl with a short debounce window.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mem_write_ctrl;
    import mem_pkg::*;

    localparam int unsigned DW = MEM_DATA_W;
    localparam int unsigned AW = MEM_ADDR_W;

    logic          clk;
    logic          rst_n;
    logic          btn_store;
    logic [DW-1:0] sw_data;
    logic [AW-1:0] sw_addr;
    logic          auto_inc;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
    logic          store;
    logic          busy;
    logic [AW-1:0] wr_ptr;

    int n_vec;
    int n_err;
    int store_cycles;
    logic [DW-1:0] log_data[$];
    logic [AW-1:0] log_addr[$];

    mem_write_ctrl #(
        .DATA_W          (DW),
        .ADDR_W          (AW),
        .DEBOUNCE_CYCLES (DEBOUNCE_SIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_store (btn_store),
        .sw_data   (sw_data),
        .sw_addr   (sw_addr),
        .auto_inc  (auto_inc),
        .data_out  (data_out),
        .addr_out  (addr_out),
        .store     (store),
        .busy      (busy),
        .wr_ptr    (wr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every store-high cycle shortly after the rising edge
    always @(posedge clk) begin
        #2;
        if (store === 1'b1) begin
            store_cycles++;
            log_data.push_back(data_out);
            log_addr.push_back(addr_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [DW-1:0] d, input int hold);
        sw_data   = d;
        btn_store = 1'b1;
        tick(hold);
        btn_store = 1'b0;
        tick(10);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        store_cycles = 0;
        rst_n     = 1'b0;
        btn_store = 1'b1;
        sw_data   = 8'hFF;
        sw_addr   = 2'd3;
        auto_inc  = 1'b0;

        // Reset held with button pressed: everything stays at zero
        for (int i = 0; i < 3; i++) begin
            tick(2);
            check("rst_store", 32'(store), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_data", 32'(data_out), 32'd0);
            check("rst_addr", 32'(addr_out), 32'd0);
            check("rst_ptr", 32'(wr_ptr), 32'd0);
        end
        btn_store = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);

        // Clean press, manual mode
        sw_data   = 8'hA5;
        sw_addr   = 2'd2;
        btn_store = 1'b1;
        tick(2);
        check("press_busy_early", 32'(busy), 32'd0);
        tick(1);
        check("press_busy_deb", 32'(busy), 32'd1);
        tick(3);
        check("press_store_pre", 32'(store), 32'd0);
        tick(1);
        check("press_store", 32'(store), 32'd1);
        check("press_data", 32'(data_out), 32'hA5);
        check("press_addr", 32'(addr_out), 32'd2);
        tick(1);
        check("press_store_post", 32'(store), 32'd0);
        tick(12);
        check("press_held_busy", 32'(busy), 32'd1);
        btn_store = 1'b0;
        tick(5);
        check("rel_busy_hold", 32'(busy), 32'd1);
        tick(1);
        check("rel_busy_fall", 32'(busy), 32'd0);
        tick(4);
        check("press_count", 32'(store_cycles), 32'd1);

        // Bounce rejection
        sw_data = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            btn_store = 1'b1;
            tick(2);
            btn_store = 1'b0;
            tick(2);
        end
        tick(10);
        check("bounce_count", 32'(store_cycles), 32'd1);
        check("bounce_busy", 32'(busy), 32'd0);
        check("bounce_follow", 32'(data_out), 32'h3C);

        // Auto-increment with wrap
        auto_inc = 1'b1;
        for (int i = 0; i < 5; i++) press(DW'(10 + i), 12);
        check("auto_count", 32'(store_cycles), 32'd6);
        check("auto_ptr", 32'(wr_ptr), 32'd1);
        if (log_data.size() >= 6) begin
            check("auto_d0", 32'(log_data[1]), 32'd10);
            check("auto_a0", 32'(log_addr[1]), 32'd0);
            check("auto_d3", 32'(log_data[4]), 32'd13);
            check("auto_a3", 32'(log_addr[4]), 32'd3);
            check("auto_d4", 32'(log_data[5]), 32'd14);
            check("auto_a4", 32'(log_addr[5]), 32'd0);
        end else begin
            check("auto_log_size", 32'(log_data.size()), 32'd6);
        end

        // Hold freeze during RELEASE
        auto_inc  = 1'b0;
        sw_data   = 8'h11;
        sw_addr   = 2'd1;
        btn_store = 1'b1;
        tick(7);
        check("frz_store", 32'(store), 32'd1);
        tick(1);
        sw_data = 8'h22;
        sw_addr = 2'd3;
        tick(2);
        check("frz_data", 32'(data_out), 32'h11);
        check("frz_addr", 32'(addr_out), 32'd1);
        btn_store = 1'b0;
        tick(6);
        check("frz_idle", 32'(busy), 32'd0);
        check("frz_data_idle", 32'(data_out), 32'h11);
        tick(1);
        check("frz_data_follow", 32'(data_out), 32'h22);
        check("frz_addr_follow", 32'(addr_out), 32'd3);
        check("frz_ptr", 32'(wr_ptr), 32'd1);

        // Reset during PULSE with button held
        auto_inc  = 1'b1;
        sw_data   = 8'h33;
        btn_store = 1'b1;
        tick(7);
        check("mid_store", 32'(store), 32'd1);
        check("mid_addr", 32'(addr_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_store", 32'(store), 32'd0);
        check("mid_rst_ptr", 32'(wr_ptr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("post_store_pre", 32'(store), 32'd0);
        tick(1);
        check("post_store", 32'(store), 32'd1);
        check("post_addr", 32'(addr_out), 32'd0);
        check("post_data", 32'(data_out), 32'h33);
        tick(12);
        btn_store = 1'b0;
        tick(10);
        check("total_count", 32'(store_cycles), 32'd9);
        check("post_ptr", 32'(wr_ptr), 32'd1);
        check("post_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_write_ctrl
